truth_sweep_gen: RTL and testbench
==================================

# truth_sweep_gen

Parametrised exhaustive-stimulus engine for combinational lab designs. On `start` it walks every `IN_W`-bit input combination in ascending order and holds each one on `dut_in` for `DWELL` clock cycles. At the end of each dwell it samples the DUT outputs and folds them into a MISR signature. It sits between the board switches/controller and the unit under test, replacing hand-written sweep benches with synthesizable hardware that supports single or continuous sweeps, pause, and a per-vector capture strobe.

## Interface
- `IN_W`, 2: DUT input width; sweep length is 2^IN_W vectors (1..16).
- `OUT_W`, 3: DUT output width; must be ≤ `SIG_W`.
- `DWELL`, 10: cycles each vector is held (≥1).
- `SIG_W`, 8: MISR width.
- `POLY`, 8'h1D: MISR feedback taps, `SIG_W` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `loop_en` in 1: 1 = restart the sweep automatically after the last vector.
- `hold` in 1: freezes the sweep while high.
- `dut_in` out IN_W: current stimulus vector, registered.
- `dut_out` in OUT_W: DUT response.
- `busy` out 1: high in RUN.
- `vec_valid` out 1: 1-cycle strobe; `cap_vec`/`cap_out` are fresh.
- `cap_vec` out IN_W: vector that was just sampled.
- `cap_out` out OUT_W: `dut_out` value that was just sampled.
- `done` out 1: 1-cycle strobe at the end of each pass.
- `sig` out SIG_W: signature of the last completed pass.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `start`=1 → RUN.
  - On entry to RUN: `vec`=0, `dwell_cnt`=0, working MISR `acc`=0.
- RUN, `hold`=0:
  - `dwell_cnt` increments each cycle.
  - At `dwell_cnt`==DWELL-1 (sample edge):
    - `acc` ← {acc[SIG_W-2:0],0} ^ (acc[SIG_W-1] ? POLY : 0) ^ zero-extended `dut_out`.
    - `cap_vec`/`cap_out` latch, and `vec_valid` is set for the next cycle.
    - `dwell_cnt` ← 0; `vec` ← vec+1.
- Last vector (2^IN_W−1) at its sample edge:
  - `sig` ← final `acc` value, including this sample.
  - `done` pulses; `acc` ← 0; `vec` wraps to 0.
  - Next state: RUN if `loop_en`=1, else IDLE.
- RUN, `hold`=1: `vec`, `dwell_cnt` and `acc` are frozen, no sampling occurs, and `busy` stays 1. When `hold` drops, the sweep resumes with the dwell count continuing from its frozen value.
- `start` in RUN is ignored. `loop_en` is evaluated only at the last-vector sample edge.
- `dut_in` always equals `vec`. In IDLE it is 0.
- `sig` is unchanged until a pass completes. An aborted pass never updates `sig`.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `vec_valid`=0, `done`=0, `cap_vec`=0, `cap_out`=0, `sig`=0. State is IDLE.
- `rst_n` low mid-sweep clears everything immediately, without waiting for a clock edge.
- `start` seen high at edge E0:
  - `busy`=1 and `dut_in`=0 from E0.
  - The first sample edge is E0+DWELL, so each vector is stable for exactly DWELL cycles before it is sampled.
- Each `vec_valid` pulse is high in the cycle following its sample edge.
- One pass lasts 2^IN_W·DWELL cycles, plus the cycles spent with `hold` high. `done` and the new `sig` are visible in the cycle after the final sample edge.
- Single-sweep mode: `busy` drops in the same cycle `done` is high, and the next `start` can be accepted at the following edge.
- Loop mode: `dut_in` returns to 0 right after the final sample edge, with no idle gap between passes.
- DWELL=1: a sample is taken every cycle and `vec_valid` stays high continuously during the sweep.
- `hold` high on a would-be sample edge: the sample is deferred until `hold` releases.

## Test plan
1. Defaults, `dut_out`={1'b0,dut_in}, `start` pulse at E0:
   - `dut_in` steps 0,1,2,3 every 10 cycles.
   - Four `vec_valid` pulses with `cap_vec`=0..3 and `cap_out`=0..3.
   - `done` at E0+40; `sig`=8'h03; `busy` low at E0+40.
2. `dut_out` tied to 3'b111:
   - Signature progression 07 → 09 → 15 → 2D.
   - Final `sig`=8'h2D.
3. `loop_en`=1 for three passes:
   - `done` pulses at E0+40, +80 and +120.
   - `sig` is identical after every pass.
   - `dut_in` shows no gap between passes.
4. `hold` high for 7 cycles while `vec`=2 and `dwell_cnt`=4:
   - `dut_in` stays 2 throughout.
   - `done` is delayed to E0+47 and `sig` is unchanged versus scenario 1.
5. `rst_n` pulsed low at E0+25:
   - All outputs return to 0 immediately; `sig` stays 0.
   - A fresh `start` then reproduces scenario 1.
6. `start` re-asserted while `busy`=1: no effect on the timing of scenario 1.

Source files
------------

// File: rtl/truth_sweep_gen_if.sv
// Bundle between the sweep engine, its controller and the unit under test.
// The engine takes the slave side; the controller and UUT together take the master side.
interface truth_sweep_gen_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int SIG_W = 8
);
  logic             start;
  logic             loop_en;
  logic             hold;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             vec_valid;
  logic [IN_W-1:0]  cap_vec;
  logic [OUT_W-1:0] cap_out;
  logic             done;
  logic [SIG_W-1:0] sig;

  modport master (
    output start, loop_en, hold, dut_out,
    input  dut_in, busy, vec_valid, cap_vec, cap_out, done, sig
  );

  modport slave (
    input  start, loop_en, hold, dut_out,
    output dut_in, busy, vec_valid, cap_vec, cap_out, done, sig
  );
endinterface

// File: rtl/truth_sweep_gen.sv
// Exhaustive stimulus engine: walks every IN_W-bit vector, holds each for DWELL cycles,
// and folds the sampled responses into a MISR signature published at the end of each pass.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; dut_in parked at 0
// ST_RUN  | sweeping vectors; dwell counter runs unless hold is high
module truth_sweep_gen #(
  parameter int                IN_W  = 2,
  parameter int                OUT_W = 3,
  parameter int                DWELL = 10,
  parameter int                SIG_W = 8,
  parameter logic [SIG_W-1:0]  POLY  = 8'h1D
) (
  input  logic               clk,
  input  logic               rst_n,
  truth_sweep_gen_if.slave   bus
);

  localparam int              CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [IN_W-1:0]  VEC_LAST   = '1;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_dwell;
  logic [IN_W-1:0]  r_vec;
  logic [SIG_W-1:0] r_acc;
  logic [SIG_W-1:0] w_acc_nxt;
  logic             r_vec_valid;
  logic             r_done;
  logic [IN_W-1:0]  r_cap_vec;
  logic [OUT_W-1:0] r_cap_out;
  logic [SIG_W-1:0] r_sig;
  logic             w_start;
  logic             w_sample;
  logic             w_last;

  assign w_start  = (r_state == ST_IDLE) && bus.start;
  assign w_sample = (r_state == ST_RUN) && !bus.hold && (r_dwell == DWELL_LAST);
  assign w_last   = (r_vec == VEC_LAST);

  always_comb begin
    w_acc_nxt = {r_acc[SIG_W-2:0], 1'b0}
              ^ (r_acc[SIG_W-1] ? POLY : {SIG_W{1'b0}})
              ^ SIG_W'(bus.dut_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // loop_en only matters at the final sample of a pass
        if (w_sample && w_last && !bus.loop_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell     <= '0;
      r_vec       <= '0;
      r_acc       <= '0;
      r_vec_valid <= 1'b0;
      r_done      <= 1'b0;
      r_cap_vec   <= '0;
      r_cap_out   <= '0;
      r_sig       <= '0;
    end else begin
      r_vec_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_start) begin
        r_dwell <= '0;
        r_vec   <= '0;
        r_acc   <= '0;
      end else if (w_sample) begin
        r_dwell     <= '0;
        r_vec       <= r_vec + 1'b1;
        r_cap_vec   <= r_vec;
        r_cap_out   <= bus.dut_out;
        r_vec_valid <= 1'b1;
        if (w_last) begin
          r_sig  <= w_acc_nxt;
          r_done <= 1'b1;
          r_acc  <= '0;
        end else begin
          r_acc <= w_acc_nxt;
        end
      end else if ((r_state == ST_RUN) && !bus.hold) begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  // vec wraps to 0 after the last vector, so it already reads 0 whenever idle
  assign bus.dut_in    = r_vec;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.vec_valid = r_vec_valid;
  assign bus.done      = r_done;
  assign bus.cap_vec   = r_cap_vec;
  assign bus.cap_out   = r_cap_out;
  assign bus.sig       = r_sig;

endmodule

// File: tb/tb_truth_sweep_gen.sv
// Scoreboard bench for truth_sweep_gen: scenarios push expected samples, pass results and
// cycle probes into queues; a negedge monitor pops and compares them against the outputs.
module tb_truth_sweep_gen;
  localparam int IN_W  = 2;
  localparam int OUT_W = 3;
  localparam int SIG_W = 8;
  localparam int DWELL = 10;

  typedef struct {int cyc; logic [IN_W-1:0] vec; logic [OUT_W-1:0] out;} samp_t;
  typedef struct {int cyc; logic [SIG_W-1:0] sig; logic busy;} done_t;
  typedef struct {int cyc; int kind; logic [IN_W-1:0] din; logic busy;} probe_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dout_all1 = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   timeouts = 0;

  samp_t  samp_q[$];
  done_t  done_q[$];
  probe_t probe_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_sweep_gen_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W)) bus ();

  truth_sweep_gen #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DWELL(DWELL), .SIG_W(SIG_W), .POLY(8'h1D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always_comb bus.dut_out = dout_all1 ? 3'b111 : {1'b0, bus.dut_in};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor: the only process that compares
  always @(negedge clk) begin
    samp_t  s;
    done_t  d;
    probe_t p;
    if (bus.vec_valid) begin
      if (samp_q.size() == 0) chk("vec_valid unexpected", 32'(bus.vec_valid), 32'd0);
      else begin
        s = samp_q.pop_front();
        chk("sample cycle", 32'(cyc), 32'(s.cyc));
        chk("cap_vec", 32'(bus.cap_vec), 32'(s.vec));
        chk("cap_out", 32'(bus.cap_out), 32'(s.out));
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) chk("done unexpected", 32'(bus.done), 32'd0);
      else begin
        d = done_q.pop_front();
        chk("done cycle", 32'(cyc), 32'(d.cyc));
        chk("sig", 32'(bus.sig), 32'(d.sig));
        chk("busy at done", 32'(bus.busy), 32'(d.busy));
      end
    end
    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
      p = probe_q.pop_front();
      case (p.kind)
        0: begin
          chk("dut_in", 32'(bus.dut_in), 32'(p.din));
          chk("busy", 32'(bus.busy), 32'(p.busy));
        end
        1: begin
          chk("rst dut_in", 32'(bus.dut_in), 32'd0);
          chk("rst busy", 32'(bus.busy), 32'd0);
          chk("rst vec_valid", 32'(bus.vec_valid), 32'd0);
          chk("rst done", 32'(bus.done), 32'd0);
          chk("rst cap_vec", 32'(bus.cap_vec), 32'd0);
          chk("rst cap_out", 32'(bus.cap_out), 32'd0);
          chk("rst sig", 32'(bus.sig), 32'd0);
        end
        default: begin
          chk("samples outstanding", 32'(samp_q.size()), 32'd0);
          chk("dones outstanding", 32'(done_q.size()), 32'd0);
          chk("wait timeouts", 32'(timeouts), 32'd0);
        end
      endcase
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_start(output int e0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic push_samp(input int c, input int v, input int o);
    samp_t s;
    s.cyc = c;
    s.vec = IN_W'(v);
    s.out = OUT_W'(o);
    samp_q.push_back(s);
  endtask

  task automatic push_done(input int c, input logic [SIG_W-1:0] sg, input logic b);
    done_t d;
    d.cyc = c;
    d.sig = sg;
    d.busy = b;
    done_q.push_back(d);
  endtask

  task automatic push_probe(input int c, input int kind, input int din, input logic b);
    probe_t p;
    p.cyc = c;
    p.kind = kind;
    p.din = IN_W'(din);
    p.busy = b;
    probe_q.push_back(p);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((samp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (samp_q.size() != 0 || done_q.size() != 0) begin
      timeouts++;
      $display("FAIL drain timeout: %0d samples and %0d dones outstanding",
               samp_q.size(), done_q.size());
      samp_q.delete();
      done_q.delete();
    end
  endtask

  // plain single pass, dut_out = {0,dut_in}; optional start re-pulses while busy
  task automatic scen_basic(input bit restart);
    int e0;
    pulse_start(e0);
    for (int k = 0; k < 4; k++) push_samp(e0 + DWELL * (k + 1), k, k);
    push_done(e0 + 40, 8'h03, 1'b0);
    for (int k = 0; k < 4; k++) push_probe(e0 + 5 + 10 * k, 0, k, 1'b1);
    push_probe(e0 + 41, 0, 0, 1'b0);
    if (restart) begin
      wait_until(e0 + 15);
      bus.start = 1'b1;
      wait_until(e0 + 17);
      bus.start = 1'b0;
      wait_until(e0 + 33);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    drain(100);
    wait_until(e0 + 43);
  endtask

  initial begin
    int e0;
    bus.start   = 1'b0;
    bus.loop_en = 1'b0;
    bus.hold    = 1'b0;
    push_probe(2, 1, 0, 1'b0);
    wait_until(3);
    rst_n = 1'b1;
    wait_until(5);

    scen_basic(1'b0);

    // dut_out stuck at 7: 07 -> 09 -> 15 -> 2D
    dout_all1 = 1'b1;
    pulse_start(e0);
    for (int k = 0; k < 4; k++) push_samp(e0 + DWELL * (k + 1), k, 7);
    push_done(e0 + 40, 8'h2D, 1'b0);
    drain(100);
    wait_until(e0 + 43);
    dout_all1 = 1'b0;

    // three back-to-back passes in loop mode
    bus.loop_en = 1'b1;
    pulse_start(e0);
    for (int k = 0; k < 12; k++) push_samp(e0 + DWELL * (k + 1), k % 4, k % 4);
    push_done(e0 + 40, 8'h03, 1'b1);
    push_done(e0 + 80, 8'h03, 1'b1);
    push_done(e0 + 120, 8'h03, 1'b0);
    push_probe(e0 + 35, 0, 3, 1'b1);
    push_probe(e0 + 40, 0, 0, 1'b1);
    push_probe(e0 + 75, 0, 3, 1'b1);
    push_probe(e0 + 80, 0, 0, 1'b1);
    push_probe(e0 + 121, 0, 0, 1'b0);
    wait_until(e0 + 100);
    bus.loop_en = 1'b0;
    drain(200);
    wait_until(e0 + 123);

    // hold for 7 edges at vec=2, dwell=4
    pulse_start(e0);
    push_samp(e0 + 10, 0, 0);
    push_samp(e0 + 20, 1, 1);
    push_samp(e0 + 37, 2, 2);
    push_samp(e0 + 47, 3, 3);
    push_done(e0 + 47, 8'h03, 1'b0);
    for (int k = 25; k <= 31; k++) push_probe(e0 + k, 0, 2, 1'b1);
    push_probe(e0 + 36, 0, 2, 1'b1);
    wait_until(e0 + 24);
    bus.hold = 1'b1;
    wait_until(e0 + 31);
    bus.hold = 1'b0;
    drain(100);
    wait_until(e0 + 50);

    // asynchronous reset mid-sweep, then a clean pass
    pulse_start(e0);
    push_samp(e0 + 10, 0, 0);
    push_samp(e0 + 20, 1, 1);
    push_probe(e0 + 25, 1, 0, 1'b0);
    push_probe(e0 + 28, 1, 0, 1'b0);
    wait_until(e0 + 24);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain(20);
    wait_until(e0 + 30);
    scen_basic(1'b0);

    // start re-asserted while busy must not disturb timing
    scen_basic(1'b1);

    push_probe(cyc + 2, 2, 0, 1'b0);
    wait_until(cyc + 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
